emblem_sequencer: RTL and testbench



---
 rtl/overlay_pkg.sv | 31 +++
 rtl/frame_down_counter.sv | 27 ++
 rtl/emblem_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_emblem_sequencer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/overlay_pkg.sv
// Shared definitions for the emblem overlay: sequencer states, fade
// levels, emblem geometry and a small slide-step helper.
package overlay_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SLIDE_IN = 3'd1,
    HOLD     = 3'd2,
    BLINK    = 3'd3,
    FADE_OUT = 3'd4
  } emb_seq_state_t;

  // Fade level for full colour; 0 is black.
  localparam logic [1:0] FADE_FULL = 2'd3;

  // Emblem placement on the 640x480 raster (inclusive bounds).
  localparam int unsigned EMBLEM_X0 = 288;
  localparam int unsigned EMBLEM_X1 = 351;
  localparam int unsigned EMBLEM_Y0 = 208;
  localparam int unsigned EMBLEM_Y1 = 271;
  localparam int unsigned EMBLEM_CX = (EMBLEM_X0 + EMBLEM_X1 + 1) / 2;
  localparam int unsigned EMBLEM_CY = (EMBLEM_Y0 + EMBLEM_Y1 + 1) / 2;

  // One slide step towards the resting position, saturating at zero so
  // a step size that does not divide the distance still lands exactly.
  function automatic logic [9:0] slide_next(input logic [9:0] x,
                                            input logic [9:0] step);
    return (x <= step) ? 10'd0 : (x - step);
  endfunction

endpackage

// File: rtl/frame_down_counter.sv
// 8-bit loadable frame down-counter. Load has priority; otherwise a tick
// decrements, stopping at zero. The zero flag is the terminal indication.
module frame_down_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       tick,
  output logic       zero
);

  logic [7:0] count;

  // Count register: reload wins over a decrement in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 8'd0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && (count != 8'd0)) begin
      count <= count - 8'd1;
    end
  end

  assign zero = (count == 8'd0);

endmodule

// File: rtl/emblem_sequencer.sv
// Frame-level controller for the emblem overlay: slide-in, hold, blink,
// fade-out. Every output is registered and only moves on frame_tick
// edges, so updates land inside vertical blank.
module emblem_sequencer
  import overlay_pkg::*;
#(
  parameter int unsigned SLIDE_DIST    = 160,
  parameter int unsigned SLIDE_STEP    = 8,
  parameter int unsigned HOLD_FRAMES   = 60,
  parameter int unsigned BLINK_PERIOD  = 8,
  parameter int unsigned BLINK_TOGGLES = 6,
  parameter int unsigned FADE_FRAMES   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       stop,
  output logic       overlay_en,
  output logic [9:0] x_offset,
  output logic [1:0] fade_level,
  output logic       busy,
  output logic       done
);

  // Parameters must fit the 8-bit frame counter, the 4-bit toggle counter
  // and the 10-bit offset; toggles must be even so BLINK ends visible.
  if (HOLD_FRAMES < 1 || HOLD_FRAMES > 256) begin : g_bad_hold
    $error("emblem_sequencer: HOLD_FRAMES must be 1..256");
  end
  if (BLINK_PERIOD < 1 || BLINK_PERIOD > 256) begin : g_bad_period
    $error("emblem_sequencer: BLINK_PERIOD must be 1..256");
  end
  if (FADE_FRAMES < 1 || FADE_FRAMES > 256) begin : g_bad_fade
    $error("emblem_sequencer: FADE_FRAMES must be 1..256");
  end
  if (BLINK_TOGGLES < 2 || BLINK_TOGGLES > 15 || (BLINK_TOGGLES % 2) != 0) begin : g_bad_toggles
    $error("emblem_sequencer: BLINK_TOGGLES must be even and 2..15");
  end
  if (SLIDE_DIST > 1023 || SLIDE_STEP < 1 || SLIDE_STEP > 1023) begin : g_bad_slide
    $error("emblem_sequencer: SLIDE_DIST/SLIDE_STEP out of range");
  end

  localparam logic [7:0] HOLD_LOAD   = 8'(HOLD_FRAMES - 1);
  localparam logic [7:0] PERIOD_LOAD = 8'(BLINK_PERIOD - 1);
  localparam logic [7:0] FADE_LOAD   = 8'(FADE_FRAMES - 1);
  localparam logic [3:0] TOGGLE_LOAD = 4'(BLINK_TOGGLES);
  localparam logic [9:0] DIST        = 10'(SLIDE_DIST);
  localparam logic [9:0] STEP        = 10'(SLIDE_STEP);

  emb_seq_state_t state, state_n;
  logic       overlay_en_n;
  logic [9:0] x_offset_n;
  logic [1:0] fade_level_n;
  logic [3:0] toggle_cnt, toggle_cnt_n;
  logic       busy_n, done_n;
  logic       start_pend, start_pend_n;
  logic       stop_pend, stop_pend_n;
  logic       start_now, stop_now;
  logic       cnt_load, cnt_tick, cnt_zero;
  logic [7:0] cnt_load_val;

  // A request arriving on the tick cycle itself counts at that edge.
  assign start_now = start_pend | start;
  assign stop_now  = stop_pend  | stop;

  frame_down_counter u_frame_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .tick     (cnt_tick),
    .zero     (cnt_zero)
  );

  // State and output registers; reset drops everything without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      overlay_en <= 1'b0;
      x_offset   <= 10'd0;
      fade_level <= 2'd0;
      toggle_cnt <= 4'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      start_pend <= 1'b0;
      stop_pend  <= 1'b0;
    end else begin
      state      <= state_n;
      overlay_en <= overlay_en_n;
      x_offset   <= x_offset_n;
      fade_level <= fade_level_n;
      toggle_cnt <= toggle_cnt_n;
      busy       <= busy_n;
      done       <= done_n;
      start_pend <= start_pend_n;
      stop_pend  <= stop_pend_n;
    end
  end

  // Next-state and next-output logic; pending requests are consumed (or
  // discarded when not applicable) at every frame tick.
  always_comb begin
    state_n      = state;
    overlay_en_n = overlay_en;
    x_offset_n   = x_offset;
    fade_level_n = fade_level;
    toggle_cnt_n = toggle_cnt;
    done_n       = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = 8'd0;
    cnt_tick     = 1'b0;
    start_pend_n = frame_tick ? 1'b0 : start_now;
    stop_pend_n  = frame_tick ? 1'b0 : stop_now;

    if (frame_tick) begin
      case (state)
        IDLE: begin
          if (!stop_now && start_now) begin
            state_n      = SLIDE_IN;
            overlay_en_n = 1'b1;
            x_offset_n   = DIST;
            fade_level_n = FADE_FULL;
          end
        end

        SLIDE_IN: begin
          if (stop_now) begin
            state_n      = FADE_OUT;
            overlay_en_n = 1'b1;
            cnt_load     = 1'b1;
            cnt_load_val = FADE_LOAD;
          end else begin
            x_offset_n = slide_next(x_offset, STEP);
            if (x_offset <= STEP) begin
              state_n      = HOLD;
              cnt_load     = 1'b1;
              cnt_load_val = HOLD_LOAD;
            end
          end
        end

        HOLD: begin
          if (stop_now) begin
            state_n      = FADE_OUT;
            overlay_en_n = 1'b1;
            cnt_load     = 1'b1;
            cnt_load_val = FADE_LOAD;
          end else if (cnt_zero) begin
            state_n      = BLINK;
            toggle_cnt_n = TOGGLE_LOAD;
            cnt_load     = 1'b1;
            cnt_load_val = PERIOD_LOAD;
          end else begin
            cnt_tick = 1'b1;
          end
        end

        BLINK: begin
          if (stop_now) begin
            state_n      = FADE_OUT;
            overlay_en_n = 1'b1;
            cnt_load     = 1'b1;
            cnt_load_val = FADE_LOAD;
          end else if (cnt_zero) begin
            overlay_en_n = ~overlay_en;
            toggle_cnt_n = toggle_cnt - 4'd1;
            cnt_load     = 1'b1;
            if (toggle_cnt == 4'd1) begin
              state_n      = FADE_OUT;
              overlay_en_n = 1'b1;
              cnt_load_val = FADE_LOAD;
            end else begin
              cnt_load_val = PERIOD_LOAD;
            end
          end else begin
            cnt_tick = 1'b1;
          end
        end

        FADE_OUT: begin
          overlay_en_n = 1'b1;
          if (cnt_zero) begin
            if (fade_level == 2'd0) begin
              state_n      = IDLE;
              overlay_en_n = 1'b0;
              x_offset_n   = 10'd0;
              toggle_cnt_n = 4'd0;
              done_n       = 1'b1;
            end else begin
              fade_level_n = fade_level - 2'd1;
              cnt_load     = 1'b1;
              cnt_load_val = FADE_LOAD;
            end
          end else begin
            cnt_tick = 1'b1;
          end
        end

        default: begin
          state_n      = IDLE;
          overlay_en_n = 1'b0;
          x_offset_n   = 10'd0;
          fade_level_n = 2'd0;
          toggle_cnt_n = 4'd0;
        end
      endcase
    end

    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_emblem_sequencer.sv
// Self-checking bench for emblem_sequencer: expected outputs come from
// closed-form per-tick formulas, are queued when the stimulus is driven
// and compared after the active edge.
module tb_emblem_sequencer;

  typedef struct packed {
    logic       en;
    logic [9:0] x;
    logic [1:0] fade;
    logic       busy;
    logic       done;
  } out_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       overlay_en;
  logic [9:0] x_offset;
  logic [1:0] fade_level;
  logic       busy;
  logic       done;

  out_t  exp_q[$];
  string tag_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  emblem_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .start      (start),
    .stop       (stop),
    .overlay_en (overlay_en),
    .x_offset   (x_offset),
    .fade_level (fade_level),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  function automatic out_t mk(input logic en, input int x, input int fade,
                              input logic bsy, input logic dn);
    out_t o;
    o.en   = en;
    o.x    = 10'(x);
    o.fade = 2'(fade);
    o.busy = bsy;
    o.done = dn;
    return o;
  endfunction

  // Default sequence, k = ticks after the tick that accepted start.
  function automatic out_t normalExp(input int k);
    if (k <= 20) return mk(1'b1, 160 - 8 * k, 3, 1'b1, 1'b0);
    if (k < 80)  return mk(1'b1, 0, 3, 1'b1, 1'b0);
    if (k < 128) return mk((((k - 80) / 8) % 2) == 0, 0, 3, 1'b1, 1'b0);
    if (k < 144) return mk(1'b1, 0, 3 - (k - 128) / 4, 1'b1, 1'b0);
    return mk(1'b0, 0, 0, 1'b0, 1'b1);
  endfunction

  // Sequence aborted by stop before tick s (while in HOLD).
  function automatic out_t stopExp(input int k, input int s);
    int d;
    if (k < s) return normalExp(k);
    d = k - s;
    if (d < 16) return mk(1'b1, 0, 3 - d / 4, 1'b1, 1'b0);
    return mk(1'b0, 0, 0, 1'b0, 1'b1);
  endfunction

  task automatic compareField(input string tag, input string field,
                              input logic [9:0] obs, input logic [9:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s.%s observed=%0d expected=%0d", tag, field, obs, expv);
    end
  endtask

  task automatic checkOutput();
    out_t  e;
    string tag;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e   = exp_q.pop_front();
    tag = tag_q.pop_front();
    compareField(tag, "overlay_en", {9'd0, overlay_en}, {9'd0, e.en});
    compareField(tag, "x_offset",   x_offset,           e.x);
    compareField(tag, "fade_level", {8'd0, fade_level}, {8'd0, e.fade});
    compareField(tag, "busy",       {9'd0, busy},       {9'd0, e.busy});
    compareField(tag, "done",       {9'd0, done},       {9'd0, e.done});
  endtask

  // Drive one cycle of inputs from a negedge; optionally queue the outputs
  // expected after the coming posedge and check them at the next negedge.
  task automatic applyStimulus(input logic r, input logic t, input logic s,
                               input logic p, input bit chk, input out_t e,
                               input string tag);
    rst = r; frame_tick = t; start = s; stop = p;
    if (chk) begin
      exp_q.push_back(e);
      tag_q.push_back(tag);
    end
    @(negedge clk);
    rst = 1'b0; frame_tick = 1'b0; start = 1'b0; stop = 1'b0;
    if (chk) checkOutput();
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One frame: nine quiet cycles then the tick cycle, checked afterwards.
  task automatic frameTick(input out_t e, input string tag);
    idleCycles(9);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, e, tag);
  endtask

  task automatic pulseStart();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, "");
  endtask

  task automatic pulseStop();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, "");
  endtask

  initial begin
    out_t zero_o;
    zero_o = mk(1'b0, 0, 0, 1'b0, 1'b0);
    @(negedge clk);

    $display("[TB] reset");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, "");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, zero_o, "reset");

    $display("[TB] full sequence with start ignored during HOLD");
    pulseStart();
    for (int k = 0; k <= 144; k++) begin
      if (k == 40) begin
        idleCycles(4);
        pulseStart();
        idleCycles(4);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, normalExp(k), $sformatf("seq_k%0d", k));
      end else begin
        frameTick(normalExp(k), $sformatf("seq_k%0d", k));
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, zero_o, "seq_done_clear");
    frameTick(zero_o, "seq_stays_idle");

    $display("[TB] stop during HOLD");
    pulseStart();
    for (int k = 0; k <= 50; k++) frameTick(stopExp(k, 51), $sformatf("stop_k%0d", k));
    idleCycles(3);
    pulseStop();
    idleCycles(5);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, stopExp(51, 51), "stop_k51");
    for (int k = 52; k <= 67; k++) frameTick(stopExp(k, 51), $sformatf("stop_k%0d", k));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, zero_o, "stop_done_clear");

    $display("[TB] start and stop together in IDLE");
    idleCycles(3);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0, "");
    frameTick(zero_o, "both_tick1");
    frameTick(zero_o, "both_tick2");

    $display("[TB] start on tick cycle, then reset mid SLIDE_IN");
    idleCycles(9);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, normalExp(0), "start_on_tick");
    for (int k = 1; k <= 10; k++) frameTick(normalExp(k), $sformatf("slide_k%0d", k));
    idleCycles(4);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, zero_o, "reset_mid");
    frameTick(zero_o, "after_reset_tick");
    pulseStart();
    frameTick(normalExp(0), "restart_k0");
    frameTick(normalExp(1), "restart_k1");
    frameTick(normalExp(2), "restart_k2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
